// File: rtl/mul_accum_16bit.sv
// Frame accumulator for the pipelined multiplier's product stream.
// Sums a programmable number of valid products into one saturated frame result.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   clr        - synchronous abort/clear (drops any product presented that cycle)
//   acc_len    - products per frame, sampled on the first product (0 acts as 1)
//   prod_en_in - product valid strobe
//   prod_in    - unsigned product value
//   acc_en_out - one-cycle pulse: acc_out/acc_ovf carry a new frame result
//   acc_out    - saturated unsigned frame sum, held until next result/clear
//   acc_ovf    - frame saturated flag, held with acc_out
//   busy       - a frame is open
module mul_accum_16bit #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned ACC_W = 20,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] acc_len,
  input  logic             prod_en_in,
  input  logic [IN_W-1:0]  prod_in,
  output logic             acc_en_out,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_ovf,
  output logic             busy
);

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   acc_out_q, acc_out_d;
  logic               acc_ovf_q, acc_ovf_d;
  logic               acc_en_q, acc_en_d;

  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   sum_sat;
  logic               sum_carry;
  logic [CNT_W-1:0]   first_len;
  logic [CNT_W-1:0]   cnt_inc;

  assign prod_ext  = {{(ACC_W-IN_W){1'b0}}, prod_in};
  // One extra bit catches the carry out of the accumulator.
  assign sum       = {1'b0, acc_q} + {1'b0, prod_ext};
  assign sum_carry = sum[ACC_W];
  assign sum_sat   = sum_carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  assign first_len = (acc_len == '0) ? CNT_W'(1) : acc_len;
  assign cnt_inc   = cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    acc_out_d = acc_out_q;
    acc_ovf_d = acc_ovf_q;
    acc_en_d  = 1'b0;

    if (clr) begin
      state_d   = StIdle;
      acc_d     = '0;
      cnt_d     = '0;
      len_d     = '0;
      ovf_d     = 1'b0;
      acc_out_d = '0;
      acc_ovf_d = 1'b0;
    end else if (prod_en_in) begin
      unique case (state_q)
        StIdle: begin
          len_d = first_len;
          acc_d = prod_ext;
          cnt_d = CNT_W'(1);
          ovf_d = 1'b0;
          if (first_len == CNT_W'(1)) begin
            // Single-product frame completes on the accepting edge.
            acc_out_d = prod_ext;
            acc_ovf_d = 1'b0;
            acc_en_d  = 1'b1;
          end else begin
            state_d = StAccum;
          end
        end
        StAccum: begin
          acc_d = sum_sat;
          ovf_d = ovf_q | sum_carry;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            acc_out_d = sum_sat;
            acc_ovf_d = ovf_q | sum_carry;
            acc_en_d  = 1'b1;
            state_d   = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      ovf_q     <= 1'b0;
      acc_out_q <= '0;
      acc_ovf_q <= 1'b0;
      acc_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      ovf_q     <= ovf_d;
      acc_out_q <= acc_out_d;
      acc_ovf_q <= acc_ovf_d;
      acc_en_q  <= acc_en_d;
    end
  end

  assign acc_en_out = acc_en_q;
  assign acc_out    = acc_out_q;
  assign acc_ovf    = acc_ovf_q;
  assign busy       = (state_q == StAccum);

endmodule

// File: tb/tb_mul_accum_16bit.sv
module tb_mul_accum_16bit;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic [7:0]  acc_len;
  logic        prod_en_in;
  logic [15:0] prod_in;
  logic        acc_en_out;
  logic [19:0] acc_out;
  logic        acc_ovf;
  logic        busy;

  int checks;
  int failures;

  mul_accum_16bit #(
    .IN_W (16),
    .ACC_W(20),
    .CNT_W(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .acc_len   (acc_len),
    .prod_en_in(prod_en_in),
    .prod_in   (prod_in),
    .acc_en_out(acc_en_out),
    .acc_out   (acc_out),
    .acc_ovf   (acc_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        en;
    logic [15:0] prod;
    logic [7:0]  len;
    logic        e_en;
    logic [19:0] e_out;
    logic        e_ovf;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic c, input logic e, input logic [15:0] p, input logic [7:0] l,
                     input logic xe, input logic [19:0] xo, input logic xv, input logic xb);
    vec_t v;
    v.clr = c; v.en = e; v.prod = p; v.len = l;
    v.e_en = xe; v.e_out = xo; v.e_ovf = xv; v.e_busy = xb;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input logic xe,
                           input logic [19:0] xo, input logic xv, input logic xb);
    chk({tag, ".acc_en_out"}, idx, 32'(acc_en_out), 32'(xe));
    chk({tag, ".acc_out"},    idx, 32'(acc_out),    32'(xo));
    chk({tag, ".acc_ovf"},    idx, 32'(acc_ovf),    32'(xv));
    chk({tag, ".busy"},       idx, 32'(busy),       32'(xb));
  endtask

  // Drive one cycle of stimulus, sample 1 time unit after the edge.
  task automatic step(input logic c, input logic e, input logic [15:0] p, input logic [7:0] l);
    clr = c; prod_en_in = e; prod_in = p; acc_len = l;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0; clr = 1'b0; acc_len = 8'd0; prod_en_in = 1'b0; prod_in = 16'd0;

    // ---- Vector table ----
    // Frame len 4 of 0xFE01
    for (int i = 0; i < 3; i++) add(0, 1, 16'hFE01, 8'd4, 0, 20'h0, 0, 1);
    add(0, 1, 16'hFE01, 8'd4, 1, 20'h3F804, 0, 0);
    add(0, 0, 16'h0,    8'd4, 0, 20'h3F804, 0, 0);
    // Frame len 3 with gaps; acc_len changed to 7 mid-frame
    add(0, 1, 16'd10, 8'd3, 0, 20'h3F804, 0, 1);
    add(0, 0, 16'd0,  8'd7, 0, 20'h3F804, 0, 1);
    add(0, 0, 16'd0,  8'd7, 0, 20'h3F804, 0, 1);
    add(0, 1, 16'd20, 8'd7, 0, 20'h3F804, 0, 1);
    add(0, 0, 16'd0,  8'd7, 0, 20'h3F804, 0, 1);
    add(0, 1, 16'd30, 8'd7, 1, 20'd60, 0, 0);
    add(0, 0, 16'd0,  8'd7, 0, 20'd60, 0, 0);
    // Frame len 17 of 0xFE01 saturates
    for (int i = 0; i < 16; i++) add(0, 1, 16'hFE01, 8'd17, 0, 20'd60, 0, 1);
    add(0, 1, 16'hFE01, 8'd17, 1, 20'hFFFFF, 1, 0);
    // len 1 frame right after clears ovf
    add(0, 1, 16'd5, 8'd1, 1, 20'd5, 0, 0);
    add(0, 0, 16'd0, 8'd1, 0, 20'd5, 0, 0);
    // Back-to-back len 2
    add(0, 1, 16'd1, 8'd2, 0, 20'd5, 0, 1);
    add(0, 1, 16'd2, 8'd2, 1, 20'd3, 0, 0);
    add(0, 1, 16'd3, 8'd2, 0, 20'd3, 0, 1);
    add(0, 1, 16'd4, 8'd2, 1, 20'd7, 0, 0);
    // len 0 acts as 1
    add(0, 1, 16'd9, 8'd0, 1, 20'd9, 0, 0);
    add(0, 0, 16'd0, 8'd0, 0, 20'd9, 0, 0);
    // clr mid-frame with product present
    add(0, 1, 16'd100, 8'd4, 0, 20'd9, 0, 1);
    add(0, 1, 16'd200, 8'd4, 0, 20'd9, 0, 1);
    add(1, 1, 16'd300, 8'd4, 0, 20'd0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 16'd1, 8'd4, 0, 20'd0, 0, 1);
    add(0, 1, 16'd1, 8'd4, 1, 20'd4, 0, 0);
    add(0, 0, 16'd0, 8'd4, 0, 20'd4, 0, 0);
    // clr on the completing cycle suppresses the result
    add(0, 1, 16'd7, 8'd2, 0, 20'd4, 0, 1);
    add(1, 1, 16'd8, 8'd2, 0, 20'd0, 0, 0);
    add(0, 0, 16'd0, 8'd2, 0, 20'd0, 0, 0);
    // Frame after that starts cleanly
    add(0, 1, 16'd11, 8'd2, 0, 20'd0, 0, 1);
    add(0, 1, 16'd12, 8'd2, 1, 20'd23, 0, 0);

    // ---- Reset state ----
    #3;
    check_all("reset", 0, 1'b0, 20'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 16'd0, 8'd0);
      check_all("idle", i, 1'b0, 20'd0, 1'b0, 1'b0);
    end

    // ---- Table-driven vectors ----
    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].en, vecs[i].prod, vecs[i].len);
      check_all("vec", i, vecs[i].e_en, vecs[i].e_out, vecs[i].e_ovf, vecs[i].e_busy);
    end

    // ---- Asynchronous reset in the middle of a frame ----
    step(0, 1, 16'hFE01, 8'd4);
    step(0, 1, 16'hFE01, 8'd4);
    check_all("pre_rst", 0, 1'b0, 20'd23, 1'b0, 1'b1);
    prod_en_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_all("async_rst", 0, 1'b0, 20'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 16'd0, 8'd4);
      check_all("post_rst", i, 1'b0, 20'd0, 1'b0, 1'b0);
    end
    // Earlier partial frame must not leak into a new one
    step(0, 1, 16'd3, 8'd2);
    check_all("post_rst_f", 0, 1'b0, 20'd0, 1'b0, 1'b1);
    step(0, 1, 16'd4, 8'd2);
    check_all("post_rst_f", 1, 1'b1, 20'd7, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
